// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: FSM states and fetch constants.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    localparam logic [31:0] EBREAK = 32'h0010_0073;
    localparam logic [31:0] PC_INC = 32'd4;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives a synchronous ROM, presents one instruction per cycle
// to decode with valid/ready backpressure, branch redirect, and EBREAK/misalign halt.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_instr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_pc,
    output logic [31:0]       out_instr,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic              halted,
    output logic              misalign_err,
    output logic [31:0]       retired_count
);

    state_t      state;
    state_t      state_next;
    logic [31:0] fetch_pc;
    logic [31:0] req_pc;
    logic        req_valid;

    logic        redirect_ok;
    logic        redirect_bad;
    logic        live;
    logic        transfer;
    logic        advance;
    logic        is_ebreak;

    assign redirect_ok  = (state == ST_RUN) && redirect_valid && (redirect_pc[1:0] == 2'b00);
    assign redirect_bad = (state == ST_RUN) && redirect_valid && (redirect_pc[1:0] != 2'b00);
    assign live         = (state == ST_RUN) && req_valid && !redirect_valid;
    assign transfer     = live && out_ready;
    assign advance      = transfer || ((state == ST_RUN) && !req_valid);
    assign is_ebreak    = (imem_instr == EBREAK);

    assign out_pc    = req_pc;
    assign out_instr = imem_instr;

    // NOTE: sequential state uses non-blocking <= so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_FILL;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: default assignment first so no path leaves state_next unassigned (no latch).
        state_next = state;
        case (state)
            ST_FILL: state_next = ST_RUN;
            ST_RUN: begin
                if (redirect_bad || (transfer && is_ebreak)) begin
                    state_next = ST_HALT;
                end
            end
            ST_HALT: state_next = ST_HALT;
            default: state_next = ST_FILL;
        endcase
    end

    // Stalls and halt re-issue req_pc, so the ROM output stays on the presented word.
    always_comb begin
        out_valid = 1'b0;
        halted    = (state == ST_HALT);
        imem_addr = req_pc[ADDR_W+1:2];
        case (state)
            ST_FILL: imem_addr = RESET_PC[ADDR_W+1:2];
            ST_RUN: begin
                out_valid = live;
                if (redirect_ok) begin
                    imem_addr = redirect_pc[ADDR_W+1:2];
                end else if (advance) begin
                    imem_addr = fetch_pc[ADDR_W+1:2];
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc      <= RESET_PC;
            req_pc        <= RESET_PC;
            req_valid     <= 1'b0;
            misalign_err  <= 1'b0;
            retired_count <= 32'd0;
        end else begin
            case (state)
                ST_FILL: begin
                    req_pc    <= RESET_PC;
                    req_valid <= 1'b1;
                    fetch_pc  <= RESET_PC + PC_INC;
                end
                ST_RUN: begin
                    if (redirect_ok) begin
                        req_pc    <= redirect_pc;
                        req_valid <= 1'b1;
                        fetch_pc  <= redirect_pc + PC_INC;
                    end else if (redirect_bad) begin
                        misalign_err <= 1'b1;
                    end else if (advance) begin
                        req_pc    <= fetch_pc;
                        req_valid <= 1'b1;
                        fetch_pc  <= fetch_pc + PC_INC;
                    end
                    if (transfer) begin
                        retired_count <= retired_count + 32'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a transaction-level model of the presented
// instruction stream, checked every cycle, plus directed literal expectations.
module tb_fetch_unit;

    localparam int          ADDR_W   = 5;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] EBRK     = 32'h0010_0073;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_instr;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [31:0]       out_pc;
    logic [31:0]       out_instr;
    logic              redirect_valid = 1'b0;
    logic [31:0]       redirect_pc = 32'd0;
    logic              halted;
    logic              misalign_err;
    logic [31:0]       retired_count;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] rom [32];

    fetch_unit #(.RESET_PC(RESET_PC), .ADDR_W(ADDR_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halted         (halted),
        .misalign_err   (misalign_err),
        .retired_count  (retired_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) imem_instr <= rom[imem_addr];

    // Model: phase 0 = filling, 1 = presenting m_pc, 2 = halted.
    int          m_phase = 0;
    logic [31:0] m_pc    = RESET_PC;
    logic [31:0] m_count = 32'd0;
    logic        m_err   = 1'b0;

    function automatic logic [31:0] rom_word(input logic [31:0] pc);
        logic [31:0] w;
        w = pc >> 2;
        return rom[w % 32];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0;
            m_pc    = RESET_PC;
            m_count = 32'd0;
            m_err   = 1'b0;
        end else if (m_phase == 0) begin
            m_phase = 1;
            m_pc    = RESET_PC;
        end else if (m_phase == 1) begin
            if (redirect_valid) begin
                if (redirect_pc % 4 != 0) begin
                    m_err   = 1'b1;
                    m_phase = 2;
                end else begin
                    m_pc = redirect_pc;
                end
            end else if (out_ready) begin
                m_count = m_count + 32'd1;
                if (rom_word(m_pc) == EBRK) m_phase = 2;
                m_pc = m_pc + 32'd4;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic exp_valid;
        exp_valid = (m_phase == 1) && !redirect_valid;
        check("out_valid", {31'd0, out_valid}, {31'd0, exp_valid});
        check("halted", {31'd0, halted}, {31'd0, m_phase == 2});
        check("misalign_err", {31'd0, misalign_err}, {31'd0, m_err});
        check("retired_count", retired_count, m_count);
        if (exp_valid) begin
            check("out_pc", out_pc, m_pc);
            check("out_instr", out_instr, rom_word(m_pc));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // mode 0: counting ROM, 1: counting ROM with EBREAK at word 3, 2: random ROM
    task automatic do_reset(input int mode);
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        for (int k = 0; k < 32; k++) begin
            rom[k] = (mode == 2) ? $urandom : 32'h1000_0000 + k;
        end
        if (mode == 1) rom[3] = EBRK;
        if (mode == 2 && $urandom_range(0, 1) == 1) rom[$urandom_range(0, 31)] = EBRK;
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;

        // Reset release and in-order streaming
        do_reset(0);
        check("fill_valid", {31'd0, out_valid}, 32'd0);
        check("fill_addr", {27'd0, imem_addr}, 32'd0);
        check("fill_retired", retired_count, 32'd0);
        cyc();
        check("first_pc", out_pc, 32'h0);
        check("first_instr", out_instr, 32'h1000_0000);
        check("first_valid", {31'd0, out_valid}, 32'd1);
        cyc();
        check("pc4", out_pc, 32'h4);
        cyc();
        check("pc8", out_pc, 32'h8);
        check("retired_before_stall", retired_count, 32'd2);

        // Backpressure at 0x8
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cyc();
            check("stall_pc", out_pc, 32'h8);
            check("stall_instr", out_instr, 32'h1000_0002);
            check("stall_retired", retired_count, 32'd2);
        end
        out_ready = 1'b1;
        cyc();
        check("after_stall_pc", out_pc, 32'hC);
        check("after_stall_retired", retired_count, 32'd3);
        cyc();
        check("pc10", out_pc, 32'h10);

        // Redirect to 0x40
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        #1;
        check("redirect_squash", {31'd0, out_valid}, 32'd0);
        cyc();
        redirect_valid = 1'b0;
        check("redirect_pc", out_pc, 32'h40);
        check("redirect_instr", out_instr, 32'h1000_0010);
        check("redirect_retired", retired_count, 32'd4);
        cyc();

        // Wrap of the word address past word 31
        redirect_valid = 1'b1;
        redirect_pc    = 32'h78;
        cyc();
        redirect_valid = 1'b0;
        cyc();
        cyc();
        check("wrap_pc", out_pc, 32'h80);
        check("wrap_instr", out_instr, 32'h1000_0000);
        check("wrap_retired", retired_count, 32'd7);

        // EBREAK at word 3
        do_reset(1);
        for (int k = 0; k < 4; k++) cyc();
        check("ebreak_pc", out_pc, 32'hC);
        check("ebreak_instr", out_instr, EBRK);
        cyc();
        check("ebreak_halted", {31'd0, halted}, 32'd1);
        check("ebreak_retired", retired_count, 32'd4);
        check("ebreak_addr", {27'd0, imem_addr}, 32'd4);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        for (int k = 0; k < 3; k++) begin
            cyc();
            check("halt_ignores_redirect", {31'd0, out_valid}, 32'd0);
            check("halt_addr_held", {27'd0, imem_addr}, 32'd4);
            check("halt_retired", retired_count, 32'd4);
        end
        redirect_valid = 1'b0;

        // Misaligned redirect, then mid-stream reset
        do_reset(0);
        cyc();
        cyc();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h42;
        #1;
        check("misalign_squash", {31'd0, out_valid}, 32'd0);
        cyc();
        redirect_valid = 1'b0;
        check("misalign_err", {31'd0, misalign_err}, 32'd1);
        check("misalign_halted", {31'd0, halted}, 32'd1);
        check("misalign_retired", retired_count, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_misalign", {31'd0, misalign_err}, 32'd0);
        check("rst_retired", retired_count, 32'd0);
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        cyc();
        rst_n = 1'b1;
        cyc();
        check("restart_pc", out_pc, RESET_PC);
        check("restart_instr", out_instr, 32'h1000_0000);

        // Randomized traffic against the model
        do_reset(2);
        for (int i = 0; i < 4000; i++) begin
            if ((m_phase == 2 && $urandom_range(0, 3) == 0) || $urandom_range(0, 299) == 0) begin
                do_reset(2);
                continue;
            end
            out_ready      = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 7) == 0);
            case ($urandom_range(0, 15))
                0: begin
                    r      = $urandom;
                    r[1:0] = 2'($urandom_range(1, 3));
                end
                1: r = $urandom & 32'hFFFF_FFFC;
                2: r = 32'hFFFF_FFF8;
                default: r = 32'($urandom_range(0, 31)) << 2;
            endcase
            redirect_pc = r;
            cyc();
        end
        redirect_valid = 1'b0;
        cyc();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, the byte address fetched first after reset.
REQ-002 The block SHALL have parameter ADDR_W, default 5, the instruction memory word-address width (32 words).
REQ-003 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 Port imem_addr, output, ADDR_W: word address to the synchronous instruction ROM.
REQ-006 Port imem_instr, input, 32: ROM data, valid one cycle after the address is sampled.
REQ-007 Port out_valid, output, 1: out_pc/out_instr hold a live instruction for decode.
REQ-008 Port out_ready, input, 1: decode accepts; transfer occurs when out_valid && out_ready.
REQ-009 Port out_pc, output, 32: byte address of out_instr.
REQ-010 Port out_instr, output, 32: fetched instruction.
REQ-011 Port redirect_valid, input, 1: branch/jump taken; squash and refetch.
REQ-012 Port redirect_pc, input, 32: redirect target byte address.
REQ-013 Port halted, output, 1: fetch stopped (EBREAK accepted or misaligned redirect).
REQ-014 Port misalign_err, output, 1: sticky; redirect_pc[1:0] != 0 was seen.
REQ-015 Port retired_count, output, 32: number of accepted transfers.

Function
REQ-016 The block SHALL implement FSM states FILL, RUN, HALT: FILL -> RUN after one cycle; RUN -> HALT on EBREAK transfer or misaligned redirect; HALT exits only via reset.
REQ-017 The block SHALL keep fetch_pc (next address to issue) and req_pc/req_valid (address issued last cycle, whose data is on imem_instr).
REQ-018 In FILL, imem_addr SHALL be RESET_PC[ADDR_W+1:2], out_valid 0; next cycle req_pc=RESET_PC, req_valid=1, fetch_pc=RESET_PC+4.
REQ-019 In RUN, out_valid SHALL equal req_valid && !redirect_valid; out_instr SHALL be imem_instr combinationally; out_pc SHALL be req_pc.
REQ-020 Stall (out_valid && !out_ready, no redirect): imem_addr SHALL be req_pc[ADDR_W+1:2] and fetch_pc/req_pc SHALL hold, so the same word is re-read and outputs stay stable.
REQ-021 Advance (transfer, or !req_valid): imem_addr SHALL be fetch_pc[ADDR_W+1:2]; next cycle req_pc=fetch_pc, req_valid=1, fetch_pc+=4.
REQ-022 Redirect (aligned) SHALL take priority over stall/advance: imem_addr SHALL be redirect_pc[ADDR_W+1:2] in the same cycle; next cycle req_pc=redirect_pc, req_valid=1, fetch_pc=redirect_pc+4; exactly one instruction squashed.
REQ-023 Misaligned redirect SHALL set misalign_err, squash, and enter HALT next cycle.
REQ-024 fetch_pc arithmetic SHALL be 32-bit modulo 2^32; imem_addr uses bits [ADDR_W+1:2] only, so 0x7C -> 0x80 wraps to word 0 while out_pc shows 0x80.
REQ-025 A transfer with out_instr == 32'h0010_0073 (EBREAK) SHALL complete, count, and enter HALT next cycle.
REQ-026 In HALT, out_valid SHALL be 0, halted 1, redirect_valid ignored, imem_addr held.
REQ-027 retired_count SHALL increment by 1 per transfer, wrapping at 2^32.

Reset
REQ-028 On rst_n low, asynchronously: state=FILL, fetch_pc=RESET_PC, req_pc=RESET_PC, req_valid=0, halted=0, misalign_err=0, retired_count=0; out_valid=0.
REQ-029 Reset asserted mid-stream SHALL discard all in-flight fetches; first instruction after release is at RESET_PC, at the second edge after release.

Structure
REQ-030 Package fetch_pkg SHALL hold the FSM state enum, the EBREAK constant, and the PC increment (4).
REQ-031 No sub-module; single module, registers plus combinational address mux.

Verification
REQ-032 ROM words i = 0x1000_0000+i, out_ready=1: release reset -> out_valid at 2nd edge, out_pc 0,4,8... one per cycle, instr matches.
REQ-033 out_ready low 3 cycles at out_pc=0x8 -> out_pc/out_instr stable 0x8/0x1000_0002, then 0xC next cycle after ready rises; retired_count +1 only once.
REQ-034 redirect_valid with redirect_pc=0x40 while out_pc=0x10 -> out_valid 0 that cycle; next cycle out_pc=0x40, instr 0x1000_0010.
REQ-035 Free-run past word 31 -> out_pc 0x80 with instr 0x1000_0000 (wrap).
REQ-036 Word 3 = 0x0010_0073 -> transfer at out_pc=0xC, halted=1 next cycle, out_valid stays 0, retired_count=4, redirects ignored.
REQ-037 redirect_pc=0x42 -> misalign_err=1, halted=1 next cycle; rst_n pulse mid-stream -> all outputs to reset values, restart at RESET_PC.
